// File: rtl/ram_sdp_ctrl.sv
// Arbitrating controller for a simple-dual-port RAM: two round-robin write requesters and one read port.
// Grants are combinational. Read data arrives one cycle after acceptance. A zero-fill sweep blocks all requests.
module ram_sdp_ctrl #(
  parameter int addr_bits = 8,
  parameter int data_bits = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  output logic                 init_busy,
  input  logic                 wr0_req,
  input  logic [addr_bits-1:0] wr0_addr,
  input  logic [data_bits-1:0] wr0_data,
  output logic                 wr0_gnt,
  input  logic                 wr1_req,
  input  logic [addr_bits-1:0] wr1_addr,
  input  logic [data_bits-1:0] wr1_data,
  output logic                 wr1_gnt,
  input  logic                 rd_req,
  input  logic [addr_bits-1:0] rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic [data_bits-1:0] rd_data,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [addr_bits-1:0] ram_addra,
  output logic [data_bits-1:0] ram_dia,
  output logic [addr_bits-1:0] ram_addrb,
  input  logic [data_bits-1:0] ram_dob
);

  typedef enum logic {RUN, CLEAR} state_t;

  state_t                 state_q;
  logic [addr_bits-1:0]   clr_cnt_q;
  logic                   last_q;      // 0: wr0 granted last, 1: wr1 granted last
  logic                   rd_valid_q;
  logic                   byp_q;
  logic [data_bits-1:0]   byp_data_q;

  logic                   g0_d, g1_d, rg_d, wr_any_d, byp_d;
  logic [addr_bits-1:0]   waddr_d;
  logic [data_bits-1:0]   wdata_d;

  always_comb begin
    g0_d      = 1'b0;
    g1_d      = 1'b0;
    rg_d      = 1'b0;
    ram_we    = 1'b0;
    ram_addra = '0;
    ram_dia   = '0;
    ram_addrb = '0;
    if (!rst && state_q == RUN) begin
      if (wr0_req && wr1_req) begin
        g0_d = last_q;
        g1_d = !last_q;
      end else begin
        g0_d = wr0_req;
        g1_d = wr1_req;
      end
      rg_d = rd_req;
    end
    wr_any_d = g0_d | g1_d;
    waddr_d  = g1_d ? wr1_addr : wr0_addr;
    wdata_d  = g1_d ? wr1_data : wr0_data;
    if (!rst && state_q == CLEAR) begin
      ram_we    = 1'b1;
      ram_addra = clr_cnt_q;
    end else if (wr_any_d) begin
      ram_we    = 1'b1;
      ram_addra = waddr_d;
      ram_dia   = wdata_d;
    end
    if (rg_d) ram_addrb = rd_addr;
    ram_en = ram_we | rg_d;
    // RAM reads old contents on a same-address collision, so forward the write data.
    byp_d  = rg_d && wr_any_d && (rd_addr == waddr_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      clr_cnt_q  <= '0;
      last_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      rd_valid_q <= rg_d;
      byp_q      <= byp_d;
      if (byp_d) byp_data_q <= wdata_d;
      if (g0_d) last_q <= 1'b0;
      if (g1_d) last_q <= 1'b1;
      case (state_q)
        RUN: begin
          if (init) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
          end
        end
        CLEAR: begin
          if (init) begin
            clr_cnt_q <= '0;
          end else if (clr_cnt_q == '1) begin
            state_q   <= RUN;
            clr_cnt_q <= '0;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign wr0_gnt   = g0_d;
  assign wr1_gnt   = g1_d;
  assign rd_gnt    = rg_d;
  assign init_busy = (state_q == CLEAR);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = !rd_valid_q ? '0 : (byp_q ? byp_data_q : ram_dob);

endmodule

// File: tb/tb_ram_sdp_ctrl.sv
// Bench for ram_sdp_ctrl with a behavioural SDP RAM; read data is checked by a queue-based scoreboard.
module tb_ram_sdp_ctrl;
  localparam int AW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, init;
  logic          wr0_req, wr1_req, rd_req;
  logic [AW-1:0] wr0_addr, wr1_addr, rd_addr;
  logic [DW-1:0] wr0_data, wr1_data;
  logic          wr0_gnt, wr1_gnt, rd_gnt, rd_valid, init_busy;
  logic [DW-1:0] rd_data;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dia;
  logic [DW-1:0] ram_dob;
  logic          mem_load;
  logic [DW-1:0] mem [16];

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  ram_sdp_ctrl #(.addr_bits(AW), .data_bits(DW)) dut (
    .clk(clk), .rst(rst), .init(init), .init_busy(init_busy),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addra(ram_addra), .ram_dia(ram_dia),
    .ram_addrb(ram_addrb), .ram_dob(ram_dob)
  );

  // Read-first SDP RAM, output register gated by ram_en.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'hA000 + 16'(i);
      ram_dob <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addra] <= ram_dia;
      ram_dob <= mem[ram_addrb];
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {15'b0, act}, {15'b0, exp});
  endtask

  task automatic chka(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    chk(nm, {12'b0, act}, {12'b0, exp});
  endtask

  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 data %h expected no read", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin wr1_req = 1'b1; wr1_addr = a; wr1_data = d; end
    else      begin wr0_req = 1'b1; wr0_addr = a; wr0_data = d; end
    @(negedge clk);
    chkb("wr_gnt", port ? wr1_gnt : wr0_gnt, 1'b1);
    step();
    wr0_req = 1'b0;
    wr1_req = 1'b0;
  endtask

  task automatic do_rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
    rd_req = 1'b1;
    rd_addr = a;
    exp_q.push_back(e);
    @(negedge clk);
    chkb("rd_gnt", rd_gnt, 1'b1);
    chka("ram_addrb", ram_addrb, a);
    step();
    rd_req = 1'b0;
  endtask

  initial begin
    #100000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [3:0] exp_g0;
    rst = 1'b1; mem_load = 1'b1; init = 1'b0;
    wr0_req = 1'b1; wr1_req = 1'b1; rd_req = 1'b1;
    wr0_addr = 4'd1; wr1_addr = 4'd2; rd_addr = 4'd3;
    wr0_data = 16'h1111; wr1_data = 16'h2222;
    step();
    // Outputs forced low under reset even with requests pending.
    chkb("rst_wr0_gnt", wr0_gnt, 1'b0);
    chkb("rst_wr1_gnt", wr1_gnt, 1'b0);
    chkb("rst_rd_gnt", rd_gnt, 1'b0);
    chkb("rst_init_busy", init_busy, 1'b0);
    chkb("rst_rd_valid", rd_valid, 1'b0);
    chkb("rst_ram_en", ram_en, 1'b0);
    chkb("rst_ram_we", ram_we, 1'b0);
    chka("rst_ram_addra", ram_addra, 4'd0);
    chka("rst_ram_addrb", ram_addrb, 4'd0);
    chk("rst_ram_dia", ram_dia, 16'h0000);
    step();
    rst = 1'b0; mem_load = 1'b0; rd_req = 1'b0;

    // Round robin starting with wr0 after reset.
    wr0_data = 16'h0101; wr1_data = 16'h0202;
    exp_g0 = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chkb("rr_wr0_gnt", wr0_gnt, exp_g0[k]);
      chkb("rr_wr1_gnt", wr1_gnt, !exp_g0[k]);
      chkb("rr_ram_we", ram_we, 1'b1);
      chka("rr_ram_addra", ram_addra, exp_g0[k] ? 4'd1 : 4'd2);
      chk("rr_ram_dia", ram_dia, exp_g0[k] ? 16'h0101 : 16'h0202);
      step();
    end
    wr0_req = 1'b0;
    @(negedge clk);
    chkb("single_wr1_gnt", wr1_gnt, 1'b1);
    chkb("single_wr0_gnt", wr0_gnt, 1'b0);
    step();
    wr1_req = 1'b0;
    @(negedge clk);
    chkb("idle_ram_en", ram_en, 1'b0);
    step();

    // Zero-fill sweep with requests held across it.
    init = 1'b1;
    @(negedge clk);
    chkb("init_run_busy", init_busy, 1'b0);
    step();
    init = 1'b0;
    wr0_req = 1'b1; wr0_addr = 4'd3; wr0_data = 16'h3333;
    rd_req = 1'b1; rd_addr = 4'd7;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chkb("clr_busy", init_busy, 1'b1);
      chkb("clr_we", ram_we, 1'b1);
      chkb("clr_en", ram_en, 1'b1);
      chka("clr_addra", ram_addra, 4'(i));
      chk("clr_dia", ram_dia, 16'h0000);
      chkb("clr_wr0_gnt", wr0_gnt, 1'b0);
      chkb("clr_rd_gnt", rd_gnt, 1'b0);
      step();
    end
    exp_q.push_back(16'h0000);
    @(negedge clk);
    chkb("post_clr_busy", init_busy, 1'b0);
    chkb("post_clr_wr0_gnt", wr0_gnt, 1'b1);
    chkb("post_clr_rd_gnt", rd_gnt, 1'b1);
    chka("post_clr_addra", ram_addra, 4'd3);
    step();
    wr0_req = 1'b0; rd_req = 1'b0;

    // Same-cycle write/read bypass.
    wr0_req = 1'b1; wr0_addr = 4'd5; wr0_data = 16'h1234;
    rd_req = 1'b1; rd_addr = 4'd5;
    exp_q.push_back(16'h1234);
    @(negedge clk);
    chkb("byp_wr0_gnt", wr0_gnt, 1'b1);
    chkb("byp_rd_gnt", rd_gnt, 1'b1);
    step();
    wr0_req = 1'b0; rd_req = 1'b0;

    // Write then read next cycle, no bypass.
    do_wr(1'b1, 4'd9, 16'hBEEF);
    do_rd(4'd9, 16'hBEEF);
    do_rd(4'd5, 16'h1234);
    do_rd(4'd1, 16'h0000);
    do_wr(1'b0, 4'd0, 16'h00AA);
    do_wr(1'b1, 4'd1, 16'h1111);
    do_wr(1'b0, 4'd2, 16'h2222);
    do_wr(1'b1, 4'd4, 16'h4444);

    // Abort a sweep in its fourth cycle.
    init = 1'b1;
    step();
    init = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chka("abort_addra", ram_addra, 4'd3);
    #2;
    rst = 1'b1;
    #1;
    chkb("abort_busy", init_busy, 1'b0);
    chkb("abort_ram_en", ram_en, 1'b0);
    chkb("abort_ram_we", ram_we, 1'b0);
    step();
    rst = 1'b0;
    do_rd(4'd0, 16'h0000);
    do_rd(4'd1, 16'h0000);
    do_rd(4'd2, 16'h0000);
    do_rd(4'd3, 16'h3333);
    do_rd(4'd4, 16'h4444);
    do_rd(4'd5, 16'h1234);
    do_rd(4'd9, 16'hBEEF);
    step(); step();
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_sdp_ctrl.md
RAM_SDP_CTRL -- requirements
Module: ram_sdp_ctrl

Interface
REQ-001 Parameter addr_bits, default 8, SHALL set the RAM address width (depth 2^addr_bits).
REQ-002 Parameter data_bits, default 16, SHALL set the RAM data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 init  input  1  SHALL be a pulse that starts a zero-fill sweep of the whole RAM.
REQ-006 init_busy  output  1  SHALL be high while the zero-fill sweep runs.
REQ-007 wr0_req / wr0_addr / wr0_data  input  1 / addr_bits / data_bits  SHALL form write requester 0.
REQ-008 wr0_gnt  output  1  SHALL grant requester 0; the write commits at the same clock edge.
REQ-009 wr1_req / wr1_addr / wr1_data / wr1_gnt SHALL form write requester 1, identical to requester 0.
REQ-010 rd_req / rd_addr  input  1 / addr_bits  SHALL form the read request.
REQ-011 rd_gnt  output  1  SHALL signal that the read is accepted this cycle.
REQ-012 rd_valid / rd_data  output  1 / data_bits  SHALL return read data one cycle after acceptance.
REQ-013 ram_en, ram_we  output  1  SHALL drive the simple-dual-port RAM enables.
REQ-014 ram_addra / ram_dia  output  addr_bits / data_bits  SHALL drive the RAM write port.
REQ-015 ram_addrb  output  addr_bits  SHALL drive the RAM read address.
REQ-016 ram_dob  input  data_bits  SHALL carry the RAM read data, registered inside the RAM with 1-cycle latency and gated by ram_en.

Function
REQ-017 The FSM SHALL have two states, RUN and CLEAR; reset SHALL enter RUN.
REQ-018 In RUN, init=1 SHALL move the FSM to CLEAR at the next edge with clr_cnt=0.
REQ-019 In CLEAR, each cycle SHALL drive ram_we=1, ram_en=1, ram_addra=clr_cnt and ram_dia=0, then increment clr_cnt.
REQ-020 The cycle that writes address 2^addr_bits-1 SHALL be the last CLEAR cycle; the FSM SHALL return to RUN at the next edge, for exactly 2^addr_bits CLEAR cycles in total.
REQ-021 init=1 during CLEAR SHALL restart the sweep with clr_cnt=0.
REQ-022 In CLEAR, wr0_gnt, wr1_gnt and rd_gnt SHALL be 0, and init_busy SHALL equal 1.
REQ-023 In RUN, grants SHALL be combinational from the requests and the state; a request with no grant SHALL be held by its requester.
REQ-024 If exactly one write request is active, that requester SHALL be granted.
REQ-025 If both write requests are active, the requester not granted last SHALL be granted (round-robin).
REQ-026 A 1-bit pointer SHALL record the last granted requester, update only on a grant, and reset so that wr0 wins the first conflict.
REQ-027 On a write grant, ram_we=1, ram_en=1, and ram_addra/ram_dia SHALL equal the granted requester's address/data.
REQ-028 In RUN, rd_gnt SHALL equal rd_req; on acceptance, ram_addrb=rd_addr and ram_en=1.
REQ-029 ram_en SHALL be 0 in any cycle with no write and no accepted read, so ram_dob holds.
REQ-030 rd_valid SHALL be high exactly one cycle after each accepted read.
REQ-031 Bypass: if an accepted read and a granted write target the same address in the same cycle, rd_data SHALL return that cycle's write data; otherwise rd_data SHALL equal ram_dob.
REQ-032 rd_data SHALL be defined only while rd_valid=1.
REQ-033 A read issued the cycle after a write to the same address SHALL return the written data, with no bypass needed.

Reset
REQ-034 On rst assertion, all outputs SHALL immediately become 0 (grants, init_busy, rd_valid, ram_en, ram_we, addresses, data), clr_cnt=0, pointer=wr1 (so wr0 wins first), and state=RUN.
REQ-035 rst asserted mid-CLEAR SHALL abort the sweep; addresses already written stay 0 and the rest are unchanged.

Verification
REQ-036 init pulse with addr_bits=4 -> init_busy high for 16 cycles, ram_addra 0..15 with ram_dia=0, then a read of address 7 returns 0.
REQ-037 wr0 and wr1 requesting continuously -> grants alternate wr0, wr1, wr0, ...; exactly one ram_we per cycle.
REQ-038 Write 0x1234 to address 5 and read address 5 in the same cycle -> next cycle rd_valid=1, rd_data=0x1234.
REQ-039 Write 0xBEEF to address 9 at cycle N, read address 9 at N+1 -> rd_data=0xBEEF at N+2.
REQ-040 rd_req and wr0_req during CLEAR -> no grant until init_busy falls, then both are granted in the same cycle.
REQ-041 rst asserted at CLEAR cycle 3 -> init_busy=0 immediately; addresses 0..2 read 0, addresses 3+ keep their prior values.
